ram_scan_ctrl: RTL and testbench

- Parametrised successor to the 32x4 single-port RAM board wrapper.
- Internal simple dual-port RAM with one synchronous write port and one registered read port.
- Read address is either manual or an auto-scan counter that steps through every address at a programmable rate.
- Built-in clear engine zeroes the whole array.
- Instanced by the DE1_SoC top behind metastability_filter on every switch/key input; rd_addr/rd_data drive seg7 displays.

---
 rtl/ram_scan_pkg.sv | 13 +
 rtl/ram_dp.sv | 28 ++
 rtl/ram_scan_ctrl.sv | 143 ++++++++++++++
 tb/tb_ram_scan_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_scan_pkg.sv
// Shared types and sizing helpers for the scanned dual-port RAM block.
package ram_scan_pkg;

    typedef enum logic {
        S_IDLE,
        S_CLEAR
    } state_t;

    function automatic int depth_of(input int addr_width);
        return 1 << addr_width;
    endfunction

endpackage

// File: rtl/ram_dp.sv
// Simple dual-port RAM: one synchronous write port, one registered read port.
// Read-during-write to the same address returns the old word; callers add bypass.
module ram_dp
    import ram_scan_pkg::*;
#(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    localparam int DEPTH = depth_of(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_o <= mem_q[raddr_i];
    end

endmodule

// File: rtl/ram_scan_ctrl.sv
// RAM wrapper with manual or auto-scanned read address, write-first read bypass
// and a clear engine that zeroes the array one word per cycle.
module ram_scan_ctrl
    import ram_scan_pkg::*;
#(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 5,
    parameter int SCAN_DIV   = 50_000_000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  clear_req,
    input  logic                  scan_en,
    input  logic [ADDR_WIDTH-1:0] man_addr,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  busy,
    output logic                  wr_dropped
);

    localparam int DEPTH = depth_of(ADDR_WIDTH);
    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0]      DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(DEPTH - 1);

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   clr_addr_q, clr_addr_d;
    logic [ADDR_WIDTH-1:0]   scan_addr_q, scan_addr_d;
    logic [DIV_W-1:0]        div_cnt_q, div_cnt_d;
    logic                    busy_q;
    logic                    wr_dropped_q;
    logic [ADDR_WIDTH-1:0]   rd_addr_q;
    logic                    rd_valid_q;
    logic                    byp_hit_q;
    logic [DATA_WIDTH-1:0]   byp_data_q;

    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_waddr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [DATA_WIDTH-1:0]   ram_rdata;

    assign sel_addr = scan_en ? scan_addr_q : man_addr;

    // The clear engine owns the write port while active; user writes are dropped.
    // Writes are gated by reset so an abandoned clear stops at the reset edge.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wr_addr;
        mem_wdata = wr_data;
        if (reset_n) begin
            if (state_q == S_CLEAR) begin
                mem_we    = 1'b1;
                mem_waddr = clr_addr_q;
                mem_wdata = '0;
            end else if (wr_en) begin
                mem_we = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        case (state_q)
            S_IDLE: begin
                if (clear_req) begin
                    state_d    = S_CLEAR;
                    clr_addr_d = '0;
                end
            end
            S_CLEAR: begin
                clr_addr_d = clr_addr_q + ADDR_WIDTH'(1);
                if (clr_addr_q == ADDR_LAST) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        div_cnt_d   = div_cnt_q;
        scan_addr_d = scan_addr_q;
        if (scan_en) begin
            if (div_cnt_q == DIV_LAST) begin
                div_cnt_d   = '0;
                scan_addr_d = scan_addr_q + ADDR_WIDTH'(1);
            end else begin
                div_cnt_d = div_cnt_q + DIV_W'(1);
            end
        end else begin
            div_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            clr_addr_q   <= '0;
            scan_addr_q  <= '0;
            div_cnt_q    <= '0;
            busy_q       <= 1'b0;
            wr_dropped_q <= 1'b0;
            rd_addr_q    <= '0;
            rd_valid_q   <= 1'b0;
            byp_hit_q    <= 1'b0;
            byp_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            clr_addr_q   <= clr_addr_d;
            scan_addr_q  <= scan_addr_d;
            div_cnt_q    <= div_cnt_d;
            busy_q       <= (state_d == S_CLEAR);
            wr_dropped_q <= (state_q == S_CLEAR) && wr_en;
            rd_addr_q    <= sel_addr;
            rd_valid_q   <= 1'b1;
            byp_hit_q    <= mem_we && (mem_waddr == sel_addr);
            byp_data_q   <= mem_wdata;
        end
    end

    ram_dp #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (mem_waddr),
        .wdata_i (mem_wdata),
        .raddr_i (sel_addr),
        .rdata_o (ram_rdata)
    );

    assign rd_addr    = rd_addr_q;
    assign rd_data    = !rd_valid_q ? '0 : (byp_hit_q ? byp_data_q : ram_rdata);
    assign busy       = busy_q;
    assign wr_dropped = wr_dropped_q;

endmodule

// File: tb/tb_ram_scan_ctrl.sv
// Scoreboard bench for ram_scan_ctrl: a behavioural model queues the expected
// outputs for every clock, and each scenario pops and checks them after the edge.
module tb_ram_scan_ctrl;

    localparam int DW    = 4;
    localparam int AW    = 5;
    localparam int DIV   = 4;
    localparam int DEPTH = 32;

    logic          clk       = 1'b0;
    logic          reset_n   = 1'b0;
    logic          wr_en     = 1'b0;
    logic [AW-1:0] wr_addr   = '0;
    logic [DW-1:0] wr_data   = '0;
    logic          clear_req = 1'b0;
    logic          scan_en   = 1'b0;
    logic [AW-1:0] man_addr  = '0;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          busy;
    logic          wr_dropped;

    ram_scan_ctrl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .SCAN_DIV   (DIV)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .clear_req  (clear_req),
        .scan_en    (scan_en),
        .man_addr   (man_addr),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .busy       (busy),
        .wr_dropped (wr_dropped)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        bit            dk;
        bit            bz;
        bit            dr;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] m_mem   [DEPTH];
    bit            m_known [DEPTH];
    bit            m_clearing = 1'b0;
    logic [AW-1:0] m_clr  = '0;
    logic [AW-1:0] m_scan = '0;
    int            m_div  = 0;

    int n_cmp = 0;
    int n_bad = 0;

    // Advance one clock: apply the model for the current inputs, queue what the
    // DUT should show after the edge, then wait until just past the edge.
    task automatic step();
        exp_t          e;
        logic [AW-1:0] sel;
        sel = scan_en ? m_scan : man_addr;
        if (!reset_n) begin
            e.a = '0; e.d = '0; e.dk = 1'b1; e.bz = 1'b0; e.dr = 1'b0;
            m_clearing = 1'b0;
            m_clr      = '0;
            m_div      = 0;
            m_scan     = '0;
        end else begin
            e.dr = m_clearing && wr_en;
            if (m_clearing) begin
                m_mem[m_clr]   = '0;
                m_known[m_clr] = 1'b1;
                m_clearing     = (m_clr != 5'd31);
                m_clr          = m_clr + 5'd1;
            end else begin
                if (wr_en) begin
                    m_mem[wr_addr]   = wr_data;
                    m_known[wr_addr] = 1'b1;
                end
                if (clear_req) begin
                    m_clearing = 1'b1;
                    m_clr      = '0;
                end
            end
            e.a  = sel;
            e.d  = m_mem[sel];
            e.dk = m_known[sel];
            e.bz = m_clearing;
            if (scan_en) begin
                if (m_div == DIV - 1) begin
                    m_div  = 0;
                    m_scan = m_scan + 5'd1;
                end else begin
                    m_div++;
                end
            end else begin
                m_div = 0;
            end
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        reset_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            e = exp_q.pop_front();
            n_cmp++;
            if (rd_addr !== e.a || rd_data !== e.d || busy !== e.bz || wr_dropped !== e.dr) begin
                n_bad++;
                $display("FAIL reset[%0d]: got addr=%h data=%h busy=%b drop=%b, want addr=%h data=%h busy=%b drop=%b",
                         i, rd_addr, rd_data, busy, wr_dropped, e.a, e.d, e.bz, e.dr);
            end
            $display("reset[%0d]: addr=%h data=%h busy=%b drop=%b", i, rd_addr, rd_data, busy, wr_dropped);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_write_read();
        exp_t          e;
        bit            we_t [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic [AW-1:0] wa_t [4] = '{5'h15, 5'h0A, 5'h00, 5'h00};
        logic [DW-1:0] wd_t [4] = '{4'hA, 4'h5, 4'h0, 4'h0};
        logic [AW-1:0] ma_t [4] = '{5'h00, 5'h00, 5'h15, 5'h0A};
        scan_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wr_en = we_t[i]; wr_addr = wa_t[i]; wr_data = wd_t[i]; man_addr = ma_t[i];
            step();
            e = exp_q.pop_front();
            n_cmp++;
            if (rd_addr !== e.a || (e.dk && rd_data !== e.d) || busy !== e.bz || wr_dropped !== e.dr) begin
                n_bad++;
                $display("FAIL write_read[%0d]: got addr=%h data=%h busy=%b drop=%b, want addr=%h data=%h busy=%b drop=%b",
                         i, rd_addr, rd_data, busy, wr_dropped, e.a, e.d, e.bz, e.dr);
            end
            $display("write_read[%0d]: we=%b wa=%h wd=%h man=%h -> addr=%h data=%h",
                     i, we_t[i], wa_t[i], wd_t[i], ma_t[i], rd_addr, rd_data);
        end
        wr_en = 1'b0;
    endtask

    task automatic test_bypass();
        exp_t          e;
        bit            we_t [3] = '{1'b1, 1'b0, 1'b1};
        logic [AW-1:0] wa_t [3] = '{5'h03, 5'h03, 5'h04};
        logic [DW-1:0] wd_t [3] = '{4'h7, 4'h0, 4'h9};
        scan_en  = 1'b0;
        man_addr = 5'h03;
        for (int i = 0; i < 3; i++) begin
            wr_en = we_t[i]; wr_addr = wa_t[i]; wr_data = wd_t[i];
            step();
            e = exp_q.pop_front();
            n_cmp++;
            if (rd_addr !== e.a || (e.dk && rd_data !== e.d) || busy !== e.bz || wr_dropped !== e.dr) begin
                n_bad++;
                $display("FAIL bypass[%0d]: got addr=%h data=%h, want addr=%h data=%h",
                         i, rd_addr, rd_data, e.a, e.d);
            end
            $display("bypass[%0d]: we=%b wa=%h wd=%h -> addr=%h data=%h", i, we_t[i], wa_t[i], wd_t[i], rd_addr, rd_data);
        end
        wr_en = 1'b0;
    endtask

    task automatic test_clear();
        exp_t e;
        int   busy_cycles = 0;
        scan_en   = 1'b0;
        man_addr  = 5'h15;
        clear_req = 1'b1;
        for (int i = 0; i < 41; i++) begin
            if (i == 1) clear_req = 1'b0;
            wr_en = (i == 26);
            wr_addr = 5'h15;
            wr_data = 4'hF;
            step();
            e = exp_q.pop_front();
            n_cmp++;
            if (rd_addr !== e.a || (e.dk && rd_data !== e.d) || busy !== e.bz || wr_dropped !== e.dr) begin
                n_bad++;
                $display("FAIL clear[%0d]: got addr=%h data=%h busy=%b drop=%b, want addr=%h data=%h busy=%b drop=%b",
                         i, rd_addr, rd_data, busy, wr_dropped, e.a, e.d, e.bz, e.dr);
            end
            if (busy === 1'b1) busy_cycles++;
            $display("clear[%0d]: we=%b busy=%b drop=%b data=%h", i, wr_en, busy, wr_dropped, rd_data);
        end
        wr_en = 1'b0;
        n_cmp++;
        if (busy_cycles != DEPTH) begin
            n_bad++;
            $display("FAIL clear_busy_len: got %0d cycles, want %0d", busy_cycles, DEPTH);
        end
        for (int a = 0; a < DEPTH; a++) begin
            man_addr = AW'(a);
            step();
            e = exp_q.pop_front();
            n_cmp++;
            if (rd_addr !== e.a || !e.dk || rd_data !== e.d || busy !== e.bz) begin
                n_bad++;
                $display("FAIL clear_readback[%0d]: got addr=%h data=%h busy=%b, want addr=%h data=%h busy=%b",
                         a, rd_addr, rd_data, busy, e.a, e.d, e.bz);
            end
            $display("clear_readback: addr=%h data=%h", rd_addr, rd_data);
        end
    endtask

    task automatic test_scan();
        exp_t e;
        scan_en = 1'b0;
        wr_en = 1'b1; wr_addr = 5'h01; wr_data = 4'h1; step(); void'(exp_q.pop_front());
        wr_addr = 5'h1F; wr_data = 4'hC; step(); void'(exp_q.pop_front());
        wr_en = 1'b0;
        scan_en = 1'b1;
        man_addr = 5'h1F;
        reset_n = 1'b0;
        step(); void'(exp_q.pop_front());
        step(); void'(exp_q.pop_front());
        reset_n = 1'b1;
        // Full wrap through every address, then on to 0x06, then hold, then resume.
        for (int i = 0; i < 168; i++) begin
            if (i == 154) scan_en = 1'b0;
            if (i == 160) scan_en = 1'b1;
            step();
            e = exp_q.pop_front();
            n_cmp++;
            if (rd_addr !== e.a || (e.dk && rd_data !== e.d) || busy !== e.bz || wr_dropped !== e.dr) begin
                n_bad++;
                $display("FAIL scan[%0d]: got addr=%h data=%h, want addr=%h data=%h",
                         i, rd_addr, rd_data, e.a, e.d);
            end
            $display("scan[%0d]: en=%b addr=%h data=%h", i, scan_en, rd_addr, rd_data);
        end
        scan_en = 1'b0;
    endtask

    task automatic test_reset_during_clear();
        exp_t e;
        scan_en = 1'b0;
        wr_en   = 1'b1;
        for (int a = 0; a < 12; a++) begin
            wr_addr  = (a < 11) ? AW'(a) : 5'h15;
            wr_data  = (a < 10) ? DW'(a + 1) : ((a == 10) ? 4'h5 : 4'hA);
            man_addr = wr_addr;
            step();
            e = exp_q.pop_front();
            n_cmp++;
            if (rd_addr !== e.a || rd_data !== e.d || !e.dk) begin
                n_bad++;
                $display("FAIL rdc_fill[%0d]: got addr=%h data=%h, want addr=%h data=%h", a, rd_addr, rd_data, e.a, e.d);
            end
            $display("rdc_fill: addr=%h data=%h", rd_addr, rd_data);
        end
        wr_en     = 1'b0;
        man_addr  = 5'h15;
        clear_req = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (i == 1) clear_req = 1'b0;
            if (i == 11) reset_n = 1'b0;
            step();
            e = exp_q.pop_front();
            n_cmp++;
            if (rd_addr !== e.a || (e.dk && rd_data !== e.d) || busy !== e.bz || wr_dropped !== e.dr) begin
                n_bad++;
                $display("FAIL rdc_run[%0d]: got addr=%h data=%h busy=%b, want addr=%h data=%h busy=%b",
                         i, rd_addr, rd_data, busy, e.a, e.d, e.bz);
            end
            $display("rdc_run[%0d]: rst_n=%b busy=%b", i, reset_n, busy);
        end
        reset_n = 1'b1;
        for (int a = 0; a < 12; a++) begin
            man_addr = (a < 11) ? AW'(a) : 5'h15;
            step();
            e = exp_q.pop_front();
            n_cmp++;
            if (rd_addr !== e.a || !e.dk || rd_data !== e.d || busy !== 1'b0) begin
                n_bad++;
                $display("FAIL rdc_readback[%0d]: got addr=%h data=%h busy=%b, want addr=%h data=%h busy=0",
                         a, rd_addr, rd_data, busy, e.a, e.d);
            end
            $display("rdc_readback: addr=%h data=%h", rd_addr, rd_data);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_clear();
        test_scan();
        test_reset_during_clear();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, compared=%0d", n_cmp);
        $fatal(1, "timeout");
    end

endmodule
